// File: rtl/bus_arb_pkg.sv
// Shared types for the C64 bus arbiter: state and owner encodings, output decode, parameter checks.
// Pure declarations, no latency; no backpressure involved.
package bus_arb_pkg;

    localparam int LEAD_W  = 3;
    localparam int EXP_W   = 8;
    localparam int DWELL_W = 4;

    typedef enum logic [2:0] {
        CPU     = 3'd0,
        LEAD    = 3'd1,
        GRANT   = 3'd2,
        HANDOFF = 3'd3,
        RELEASE = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_VIC = 1'b0,
        OWN_EXP = 1'b1
    } owner_t;

    typedef struct packed {
        logic rdy;
        logic aec;
        logic gnt_vic;
        logic gnt_exp;
    } bus_ctl_t;

    function automatic bit params_legal(int ba_lead, int exp_max, int min_cpu);
        return (ba_lead >= 1 && ba_lead <= 7) &&
               (exp_max >= 2 && exp_max <= 255) &&
               (min_cpu >= 1 && min_cpu <= 15);
    endfunction

    // RELEASE keeps rdy low but hands the bus back, so the CPU drives before RDY rises.
    function automatic bus_ctl_t decode_ctl(arb_state_t st, owner_t own);
        bus_ctl_t c;
        c.rdy     = (st == CPU);
        c.aec     = !(st == GRANT || st == HANDOFF);
        c.gnt_vic = (st == GRANT) && (own == OWN_VIC);
        c.gnt_exp = (st == GRANT) && (own == OWN_EXP);
        return c;
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
// Load or decrement takes effect at the next edge; zero flag is combinational from the count.
// No backpressure: load wins over decrement.
module cycle_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_arbiter_aec.sv
// Shares the C64 bus between the 6502 and the video / expansion DMA requesters, driving RDY and AEC.
// Registered outputs, one update per phi2 edge; AEC falls BA_LEAD cycles after RDY (sooner on early grant).
// Requesters are level-held; expansion grants are cut at EXP_MAX and re-accepted only after MIN_CPU dwell.
module bus_arbiter_aec
    import bus_arb_pkg::*;
#(
    parameter int BA_LEAD     = 3,
    parameter bit EARLY_GRANT = 1'b0,
    parameter int EXP_MAX     = 16,
    parameter int MIN_CPU     = 2
) (
    input  logic       phi2,
    input  logic       reset,
    input  logic       req_vic,
    input  logic       req_exp,
    input  logic       r_w_6502,
    output logic       rdy,
    output logic       aec,
    output logic       gnt_vic,
    output logic       gnt_exp,
    output logic [2:0] state_dbg
);

    localparam logic [LEAD_W-1:0]  LEAD_INIT  = LEAD_W'(BA_LEAD - 1);
    localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(MIN_CPU);
    localparam logic [EXP_W-1:0]   EXP_LAST   = EXP_W'(EXP_MAX - 1);

    generate
        if (!params_legal(BA_LEAD, EXP_MAX, MIN_CPU)) begin : g_bad_params
            $error("bus_arbiter_aec: parameter out of legal range");
        end
    endgenerate

    arb_state_t       state, state_nxt;
    owner_t           owner, owner_nxt, lead_owner;
    logic [EXP_W-1:0] exp_cnt;
    logic             own_req, lead_req;
    logic             lead_load, lead_dec, lead_zero;
    logic             dwell_load, dwell_dec, dwell_zero;
    bus_ctl_t         ctl_nxt;

    assign own_req = (owner == OWN_VIC) ? req_vic : req_exp;

    // Video pre-empts an expansion request still in its lead phase without restarting the count.
    assign lead_owner = req_vic ? OWN_VIC : owner;
    assign lead_req   = (lead_owner == OWN_VIC) ? req_vic : req_exp;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        lead_load  = 1'b0;
        lead_dec   = 1'b0;
        dwell_load = 1'b0;
        case (state)
            CPU: begin
                if (req_vic) begin
                    state_nxt = LEAD;
                    owner_nxt = OWN_VIC;
                    lead_load = 1'b1;
                end else if (req_exp && dwell_zero) begin
                    state_nxt = LEAD;
                    owner_nxt = OWN_EXP;
                    lead_load = 1'b1;
                end
            end
            LEAD: begin
                owner_nxt = lead_owner;
                if (!lead_req) begin
                    state_nxt = CPU;
                end else if (lead_zero || (EARLY_GRANT && r_w_6502)) begin
                    state_nxt = GRANT;
                end else begin
                    lead_dec = 1'b1;
                end
            end
            GRANT: begin
                if (!own_req || (owner == OWN_EXP && exp_cnt == EXP_LAST)) begin
                    state_nxt = RELEASE;
                end else if (owner == OWN_EXP && req_vic) begin
                    state_nxt = HANDOFF;
                end
            end
            HANDOFF: begin
                state_nxt = GRANT;
                owner_nxt = OWN_VIC;
            end
            RELEASE: begin
                state_nxt  = CPU;
                dwell_load = (owner == OWN_EXP);
            end
            default: state_nxt = CPU;
        endcase
    end

    assign dwell_dec = (state == CPU);
    assign ctl_nxt   = decode_ctl(state_nxt, owner_nxt);

    always_ff @(posedge phi2) begin
        if (reset) begin
            state   <= CPU;
            owner   <= OWN_VIC;
            exp_cnt <= '0;
            rdy     <= 1'b1;
            aec     <= 1'b1;
            gnt_vic <= 1'b0;
            gnt_exp <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            {rdy, aec, gnt_vic, gnt_exp} <= ctl_nxt;
            if (state != GRANT && state_nxt == GRANT) begin
                exp_cnt <= '0;
            end else if (state == GRANT && owner == OWN_EXP && exp_cnt != '1) begin
                exp_cnt <= exp_cnt + EXP_W'(1);
            end
        end
    end

    cycle_down_counter #(.WIDTH(LEAD_W)) u_lead_cnt (
        .clk      (phi2),
        .reset    (reset),
        .load     (lead_load),
        .load_val (LEAD_INIT),
        .dec      (lead_dec),
        .zero     (lead_zero)
    );

    cycle_down_counter #(.WIDTH(DWELL_W)) u_dwell_cnt (
        .clk      (phi2),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (DWELL_INIT),
        .dec      (dwell_dec),
        .zero     (dwell_zero)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter_aec.sv
// Bench for bus_arbiter_aec: vector table, directed corner sequences, then random traffic vs a cycle model.
module tb_bus_arbiter_aec;

    localparam int P_CPU = 0, P_LEAD = 1, P_GRANT = 2, P_HND = 3, P_REL = 4;
    localparam int O_VIC = 0, O_EXP = 1;
    localparam int LEAD_CYC = 3, EXP_MAX = 16, MIN_CPU = 2;

    // Expected {rdy, aec, gnt_vic, gnt_exp, state_dbg}
    localparam logic [6:0] X_CPU  = 7'b1100_000;
    localparam logic [6:0] X_LEAD = 7'b0100_001;
    localparam logic [6:0] X_GRV  = 7'b0010_010;
    localparam logic [6:0] X_GRE  = 7'b0001_010;
    localparam logic [6:0] X_HND  = 7'b0000_011;
    localparam logic [6:0] X_REL  = 7'b0100_100;

    logic       phi2 = 1'b0;
    logic       reset, req_vic, req_exp, r_w;
    logic       rdy, aec, gnt_vic, gnt_exp;
    logic [2:0] state_dbg;
    logic       eg_rdy, eg_aec, eg_gnt_vic, eg_gnt_exp;
    logic [2:0] eg_state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 phi2 = ~phi2;

    bus_arbiter_aec #(.BA_LEAD(3), .EARLY_GRANT(1'b0), .EXP_MAX(16), .MIN_CPU(2)) dut (
        .phi2(phi2), .reset(reset), .req_vic(req_vic), .req_exp(req_exp), .r_w_6502(r_w),
        .rdy(rdy), .aec(aec), .gnt_vic(gnt_vic), .gnt_exp(gnt_exp), .state_dbg(state_dbg)
    );

    bus_arbiter_aec #(.BA_LEAD(3), .EARLY_GRANT(1'b1), .EXP_MAX(16), .MIN_CPU(2)) dut_eg (
        .phi2(phi2), .reset(reset), .req_vic(req_vic), .req_exp(req_exp), .r_w_6502(r_w),
        .rdy(eg_rdy), .aec(eg_aec), .gnt_vic(eg_gnt_vic), .gnt_exp(eg_gnt_exp), .state_dbg(eg_state_dbg)
    );

    typedef struct {
        int phase;
        int owner;
        int lead;
        int glen;
        int dwell;
    } model_t;

    model_t m_main, m_eg;

    function automatic model_t model_next(model_t m, bit early, bit rst, bit rv, bit re, bit rw);
        model_t n;
        bit     wants;
        int     own;
        n = m;
        if (rst) begin
            n.phase = P_CPU; n.owner = O_VIC; n.lead = 0; n.glen = 0; n.dwell = 0;
            return n;
        end
        case (m.phase)
            P_CPU: begin
                if (rv) begin
                    n.phase = P_LEAD; n.owner = O_VIC; n.lead = LEAD_CYC - 1;
                end else if (re && m.dwell == 0) begin
                    n.phase = P_LEAD; n.owner = O_EXP; n.lead = LEAD_CYC - 1;
                end
                if (m.dwell > 0) n.dwell = m.dwell - 1;
            end
            P_LEAD: begin
                own     = rv ? O_VIC : m.owner;
                wants   = (own == O_VIC) ? rv : re;
                n.owner = own;
                if (!wants) n.phase = P_CPU;
                else if (m.lead == 0 || (early && rw)) begin
                    n.phase = P_GRANT; n.glen = 0;
                end else n.lead = m.lead - 1;
            end
            P_GRANT: begin
                wants = (m.owner == O_VIC) ? rv : re;
                if (!wants || (m.owner == O_EXP && m.glen == EXP_MAX - 1)) n.phase = P_REL;
                else if (m.owner == O_EXP && rv) n.phase = P_HND;
                else if (m.owner == O_EXP) n.glen = m.glen + 1;
            end
            P_HND: begin
                n.phase = P_GRANT; n.owner = O_VIC; n.glen = 0;
            end
            default: begin
                n.phase = P_CPU;
                if (m.owner == O_EXP) n.dwell = MIN_CPU;
            end
        endcase
        return n;
    endfunction

    function automatic logic [6:0] model_out(model_t m);
        logic [6:0] o;
        o[6]   = (m.phase == P_CPU);
        o[5]   = !(m.phase == P_GRANT || m.phase == P_HND);
        o[4]   = (m.phase == P_GRANT) && (m.owner == O_VIC);
        o[3]   = (m.phase == P_GRANT) && (m.owner == O_EXP);
        o[2:0] = 3'(m.phase);
        return o;
    endfunction

    function automatic logic [6:0] dut_out();
        return {rdy, aec, gnt_vic, gnt_exp, state_dbg};
    endfunction

    function automatic logic [6:0] eg_out();
        return {eg_rdy, eg_aec, eg_gnt_vic, eg_gnt_exp, eg_state_dbg};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, take one phi2 edge, advance both models, sample 1ns later.
    task automatic step(input bit rst, input bit rv, input bit re, input bit rw);
        reset   = rst;
        req_vic = rv;
        req_exp = re;
        r_w     = rw;
        @(posedge phi2);
        m_main = model_next(m_main, 1'b0, rst, rv, re, rw);
        m_eg   = model_next(m_eg,   1'b1, rst, rv, re, rw);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         rv;
        bit         re;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rv, bit re, logic [6:0] e);
        vec_t v;
        v.rst = rst; v.rv = rv; v.re = re; v.exp = e;
        return v;
    endfunction

    vec_t tbl[34];

    initial begin
        int run, first_fall, lead_again, cpu_seen;
        bit rv_r, re_r, rst_r;

        reset = 1'b1; req_vic = 1'b0; req_exp = 1'b0; r_w = 1'b0;

        // reset, vic request, lead of 3, grant, drop, release
        tbl[0]  = mk(1, 0, 0, X_CPU);  tbl[1]  = mk(0, 0, 0, X_CPU);
        tbl[2]  = mk(0, 1, 0, X_LEAD); tbl[3]  = mk(0, 1, 0, X_LEAD);
        tbl[4]  = mk(0, 1, 0, X_LEAD); tbl[5]  = mk(0, 1, 0, X_GRV);
        tbl[6]  = mk(0, 1, 0, X_GRV);  tbl[7]  = mk(0, 0, 0, X_REL);
        tbl[8]  = mk(0, 0, 0, X_CPU);
        // aborts during lead, aec never falls
        tbl[9]  = mk(0, 1, 0, X_LEAD); tbl[10] = mk(0, 0, 0, X_CPU);
        tbl[11] = mk(0, 1, 0, X_LEAD); tbl[12] = mk(0, 1, 0, X_LEAD);
        tbl[13] = mk(0, 0, 0, X_CPU);
        // simultaneous requests: vic first, then exp, then handoff back to vic
        tbl[14] = mk(0, 1, 1, X_LEAD); tbl[15] = mk(0, 1, 1, X_LEAD);
        tbl[16] = mk(0, 1, 1, X_LEAD); tbl[17] = mk(0, 1, 1, X_GRV);
        tbl[18] = mk(0, 0, 1, X_REL);  tbl[19] = mk(0, 0, 1, X_CPU);
        tbl[20] = mk(0, 0, 1, X_LEAD); tbl[21] = mk(0, 0, 1, X_LEAD);
        tbl[22] = mk(0, 0, 1, X_LEAD); tbl[23] = mk(0, 0, 1, X_GRE);
        tbl[24] = mk(0, 1, 1, X_HND);  tbl[25] = mk(0, 1, 1, X_GRV);
        tbl[26] = mk(0, 0, 0, X_REL);  tbl[27] = mk(0, 0, 0, X_CPU);
        // reset in the middle of a grant
        tbl[28] = mk(0, 1, 0, X_LEAD); tbl[29] = mk(0, 1, 0, X_LEAD);
        tbl[30] = mk(0, 1, 0, X_LEAD); tbl[31] = mk(0, 1, 0, X_GRV);
        tbl[32] = mk(1, 1, 0, X_CPU);  tbl[33] = mk(0, 0, 0, X_CPU);

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].re, 1'b0);
            check($sformatf("vec%0d", i), {1'b0, dut_out()}, {1'b0, tbl[i].exp});
        end

        // expansion held: grant cut at EXP_MAX, then release and dwell before the next lead
        run = 0; first_fall = -1; lead_again = -1; cpu_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            step(0, 0, 1, 0);
            if (gnt_exp) begin
                if (first_fall < 0) run++;
            end else if (run > 0 && first_fall < 0) begin
                first_fall = c;
                check("exp_forced_release", {1'b0, dut_out()}, {1'b0, X_REL});
            end
            if (first_fall >= 0 && lead_again < 0) begin
                if (state_dbg == 3'd0) cpu_seen++;
                if (state_dbg == 3'd1) lead_again = c;
            end
        end
        check("exp_grant_len", 8'(run), 8'd16);
        check("exp_dwell_cpu", 8'(cpu_seen >= MIN_CPU), 8'd1);
        check("exp_relead_gap", 8'(lead_again > 0 && lead_again - first_fall >= 3), 8'd1);

        // early grant on a read cycle in lead
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("eg_lead", {1'b0, eg_out()}, {1'b0, X_LEAD});
        step(0, 1, 0, 1);
        check("eg_early_grant", {1'b0, eg_out()}, {1'b0, X_GRV});
        check("eg_normal_still_lead", {1'b0, dut_out()}, {1'b0, X_LEAD});

        // early grant instance with writes only waits the full lead
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("eg_write_lead1", {1'b0, eg_out()}, {1'b0, X_LEAD});
        step(0, 1, 0, 0);
        check("eg_write_lead2", {1'b0, eg_out()}, {1'b0, X_LEAD});
        step(0, 1, 0, 0);
        check("eg_write_grant", {1'b0, eg_out()}, {1'b0, X_GRV});

        // random traffic against the model
        step(1, 0, 0, 0);
        rv_r = 1'b0;
        re_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 11) == 0) rv_r = ~rv_r;
            if ($urandom_range(0, 29) == 0) re_r = ~re_r;
            step(rst_r, rv_r, re_r, 1'($urandom_range(0, 1)));
            check($sformatf("rand%0d", c), {1'b0, dut_out()}, {1'b0, model_out(m_main)});
            check($sformatf("rand_eg%0d", c), {1'b0, eg_out()}, {1'b0, model_out(m_eg)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
